// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage divide sequencing controller:
// state encoding, operand width and divider result field accessors.
package div_ctrl_pkg;

   localparam int DIV_W = 32;
   localparam int RES_W = 2 * DIV_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Remainder lives in the upper half of the divider result.
   function automatic logic [DIV_W-1:0] res_hi_of(input logic [RES_W-1:0] r);
      return r[RES_W-1:DIV_W];
   endfunction

   // Quotient lives in the lower half of the divider result.
   function automatic logic [DIV_W-1:0] res_lo_of(input logic [RES_W-1:0] r);
      return r[DIV_W-1:0];
   endfunction

endpackage

// File: rtl/div_ctrl.sv
// Sequencing controller between the EX stage and the shared iterative
// divider. Converts a level-held divide request into the divider's
// start/ready handshake, stalls EX while the divide is in flight, holds
// HI/LO until EX advances and lets a flushed divide drain cleanly.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 40
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   input  logic               req_signed,
   input  logic [DIV_W-1:0]   req_op1,
   input  logic [DIV_W-1:0]   req_op2,
   input  logic               ex_advance,
   input  logic               flush,
   output logic               stall_o,
   output logic               res_valid,
   output logic [DIV_W-1:0]   res_hi,
   output logic [DIV_W-1:0]   res_lo,
   output logic               div_start,
   output logic               div_signed,
   output logic [DIV_W-1:0]   div_op1,
   output logic [DIV_W-1:0]   div_op2,
   input  logic [RES_W-1:0]   div_result,
   input  logic               div_ready,
   output logic               busy,
   output logic               div_err
);

   localparam int               WD_W   = $clog2(MAX_WAIT + 1);
   localparam logic [WD_W-1:0]  WD_MAX = WD_W'(MAX_WAIT);

   state_t            state;
   logic [WD_W-1:0]   wd_cnt;

   // Main sequencer: launches the divider, captures its result, drains flushed ops.
   always_ff @(posedge clk) begin
      // NOTE: every register here uses <= so all updates see pre-edge values.
      if (rst) begin
         state      <= IDLE;
         div_start  <= 1'b0;
         div_signed <= 1'b0;
         div_op1    <= '0;
         div_op2    <= '0;
         res_hi     <= '0;
         res_lo     <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Flush wins over a simultaneous request.
               if (req_valid && !flush) begin
                  div_start  <= 1'b1;
                  div_signed <= req_signed;
                  div_op1    <= req_op1;
                  div_op2    <= req_op2;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               // Operands and sign stay frozen: the divider samples the sign late.
               if (div_ready) begin
                  div_start <= 1'b0;
                  if (flush) begin
                     state <= IDLE;
                  end else begin
                     res_hi <= res_hi_of(div_result);
                     res_lo <= res_lo_of(div_result);
                     state  <= DONE;
                  end
               end else if (flush) begin
                  // Start must stay high until the divider reports ready.
                  state <= DRAIN;
               end
            end
            DONE: begin
               if (ex_advance || flush) state <= IDLE;
            end
            DRAIN: begin
               if (div_ready) begin
                  div_start <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Watchdog: counts cycles spent waiting on the divider, flags a stuck one.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt  <= '0;
         div_err <= 1'b0;
      end else if (state == IDLE) begin
         if (req_valid && !flush) wd_cnt <= '0;
      end else if ((state == BUSY || state == DRAIN) && wd_cnt != WD_MAX) begin
         wd_cnt <= wd_cnt + 1'b1;
         if (wd_cnt == WD_MAX - 1'b1) div_err <= 1'b1;
      end
   end

   // EX stall request, decoded from the current state and the live request.
   always_comb begin
      // NOTE: default first so no path through the case leaves stall_o unassigned (no latch).
      stall_o = 1'b0;
      case (state)
         IDLE:    stall_o = req_valid && !flush;
         BUSY:    stall_o = 1'b1;
         DONE:    stall_o = 1'b0;
         DRAIN:   stall_o = req_valid;
         default: stall_o = 1'b0;
      endcase
   end

   assign res_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl with a behavioural divider model.
module tb_div_ctrl;

   logic         clk;
   logic         rst;
   logic         req_valid;
   logic         req_signed;
   logic [31:0]  req_op1;
   logic [31:0]  req_op2;
   logic         ex_advance;
   logic         flush;
   logic         stall_o;
   logic         res_valid;
   logic [31:0]  res_hi;
   logic [31:0]  res_lo;
   logic         div_start;
   logic         div_signed;
   logic [31:0]  div_op1;
   logic [31:0]  div_op2;
   logic [63:0]  div_result;
   logic         div_ready;
   logic         busy;
   logic         div_err;

   int n_vec = 0;
   int n_err = 0;
   int starts = 0;
   logic start_q;
   logic tie_low;

   div_ctrl #(.MAX_WAIT(40)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_signed (req_signed),
      .req_op1    (req_op1),
      .req_op2    (req_op2),
      .ex_advance (ex_advance),
      .flush      (flush),
      .stall_o    (stall_o),
      .res_valid  (res_valid),
      .res_hi     (res_hi),
      .res_lo     (res_lo),
      .div_start  (div_start),
      .div_signed (div_signed),
      .div_op1    (div_op1),
      .div_op2    (div_op2),
      .div_result (div_result),
      .div_ready  (div_ready),
      .busy       (busy),
      .div_err    (div_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural divider: free -> run -> end; ready held until start drops.
   logic [1:0]  m_state;
   int          m_cnt;
   logic [63:0] m_res;
   logic        m_ready;

   function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, sq, sr;
      logic [63:0] ua, ub, uq, ur;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
         sq = sa / sb;
         sr = sa % sb;
         return {sr[31:0], sq[31:0]};
      end
      ua = {32'd0, a};
      ub = {32'd0, b};
      uq = ua / ub;
      ur = ua % ub;
      return {ur[31:0], uq[31:0]};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_state <= 2'd0;
         m_cnt   <= 0;
         m_res   <= 64'd0;
         m_ready <= 1'b0;
      end else begin
         case (m_state)
            2'd0: begin
               m_ready <= 1'b0;
               if (div_start) begin
                  m_cnt   <= (div_op2 == 32'd0) ? 1 : 34;
                  m_res   <= model_div(div_signed, div_op1, div_op2);
                  m_state <= 2'd1;
               end
            end
            2'd1: begin
               if (m_cnt == 0) begin
                  m_ready <= 1'b1;
                  m_state <= 2'd2;
               end else begin
                  m_cnt <= m_cnt - 1;
               end
            end
            default: begin
               if (!div_start) begin
                  m_ready <= 1'b0;
                  m_state <= 2'd0;
               end
            end
         endcase
      end
   end

   assign div_ready  = m_ready & ~tie_low;
   assign div_result = m_ready ? m_res : 64'd0;

   // Counts divider start rising edges.
   always @(posedge clk) begin
      start_q <= div_start;
      if (div_start && !start_q) starts <= starts + 1;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "bench timed out");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one divide, wait for DONE, check result, then advance EX.
   task automatic do_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int min_lat, input int max_lat);
      int lat;
      int gaps;
      req_valid  = 1'b1;
      req_signed = sgn;
      req_op1    = a;
      req_op2    = b;
      #1;
      check({tag, "_stall_idle"}, 64'(stall_o), 64'd1);
      tick();
      check({tag, "_launch"}, {30'd0, div_start, div_signed, div_op1}, {30'd0, 1'b1, sgn, a});
      check({tag, "_op2"}, 64'(div_op2), 64'(b));
      lat  = 0;
      gaps = 0;
      while (!res_valid && lat < 100) begin
         if (!stall_o) gaps++;
         tick();
         lat++;
      end
      check({tag, "_done"}, 64'(res_valid), 64'd1);
      check({tag, "_stall_gaps"}, 64'(gaps), 64'd0);
      check({tag, "_lat_ok"}, 64'(lat >= min_lat && lat <= max_lat), 64'd1);
      check({tag, "_result"}, {res_hi, res_lo}, {exp_hi, exp_lo});
      check({tag, "_done_outs"}, {61'd0, stall_o, div_start, div_err}, 64'd0);
      ex_advance = 1'b1;
      tick();
      ex_advance = 1'b0;
      req_valid  = 1'b0;
      check({tag, "_after"}, {61'd0, res_valid, busy, div_start}, 64'd0);
   endtask

   initial begin
      int n;
      int bad;
      int s0;
      logic [63:0] held;

      rst        = 1'b1;
      tie_low    = 1'b0;
      req_valid  = 1'b0;
      req_signed = 1'b0;
      req_op1    = 32'd0;
      req_op2    = 32'd0;
      ex_advance = 1'b0;
      flush      = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_ctrl", {58'd0, busy, div_start, div_signed, div_err, res_valid, stall_o}, 64'd0);
      check("reset_ops", {div_op1, div_op2}, 64'd0);
      check("reset_res", {res_hi, res_lo}, 64'd0);

      // Main function under several operand patterns.
      do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 30, 40);
      do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 30, 40);
      do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 30, 40);
      do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 2, 6);

      // Flush mid-divide, new divide presented the next cycle.
      req_valid = 1'b1; req_signed = 1'b0; req_op1 = 32'd100; req_op2 = 32'd7;
      tick();
      for (int i = 0; i < 9; i++) tick();
      flush = 1'b1; req_valid = 1'b0;
      tick();
      flush = 1'b0; req_valid = 1'b1; req_op1 = 32'd9; req_op2 = 32'd3;
      #1;
      check("drain_entry", {60'd0, busy, div_start, res_valid, stall_o}, {60'd0, 4'b1101});
      n = 0; bad = 0;
      while (div_start && n < 100) begin
         if (res_valid || !stall_o) bad++;
         tick();
         n++;
      end
      check("drain_bounded", 64'(n < 100), 64'd1);
      check("drain_no_result", 64'(bad), 64'd0);
      check("drain_gap", {61'd0, busy, div_start, res_valid}, 64'd0);
      tick();
      check("second_launch", {31'd0, div_start, div_op1}, {31'd0, 1'b1, 32'd9});
      n = 0;
      while (!res_valid && n < 100) begin tick(); n++; end
      check("second_result", {res_hi, res_lo}, {32'd0, 32'd3});
      ex_advance = 1'b1;
      tick();
      ex_advance = 1'b0; req_valid = 1'b0;

      // DONE held by downstream stall: result and outputs stay stable.
      s0 = starts;
      req_valid = 1'b1; req_signed = 1'b0; req_op1 = 32'd100; req_op2 = 32'd7;
      n = 0;
      tick();
      while (!res_valid && n < 100) begin tick(); n++; end
      held = {res_hi, res_lo};
      check("hold_result", held, {32'd2, 32'd14});
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if ({res_hi, res_lo} !== held || stall_o || !res_valid || div_start) bad++;
      end
      check("hold_stable", 64'(bad), 64'd0);
      check("hold_single_start", 64'(starts - s0), 64'd1);
      ex_advance = 1'b1;
      tick();
      ex_advance = 1'b0; req_valid = 1'b0;
      tick();

      // Flush coinciding with div_ready: result discarded, back to IDLE.
      req_valid = 1'b1; req_signed = 1'b0; req_op1 = 32'd9; req_op2 = 32'd3;
      tick();
      n = 0;
      while (!div_ready && n < 100) begin tick(); n++; end
      check("flush_ready_seen", 64'(div_ready), 64'd1);
      flush = 1'b1; req_valid = 1'b0;
      tick();
      flush = 1'b0;
      check("flush_ready_idle", {61'd0, busy, res_valid, div_start}, 64'd0);
      check("flush_ready_discard", {res_hi, res_lo}, {32'd2, 32'd14});
      tick();

      // Reset pulse mid-divide.
      req_valid = 1'b1; req_signed = 1'b1; req_op1 = 32'd100; req_op2 = 32'd7;
      tick(); tick(); tick();
      rst = 1'b1; req_valid = 1'b0;
      tick();
      rst = 1'b0;
      check("rst_mid_ctrl", {58'd0, busy, div_start, div_signed, div_err, res_valid, stall_o}, 64'd0);
      check("rst_mid_ops", {div_op1, div_op2}, 64'd0);
      check("rst_mid_res", {res_hi, res_lo}, 64'd0);

      // Watchdog with div_ready tied low.
      tie_low = 1'b1;
      req_valid = 1'b1; req_signed = 1'b0; req_op1 = 32'd100; req_op2 = 32'd7;
      tick();
      for (int i = 0; i < 39; i++) tick();
      check("wd_before_limit", 64'(div_err), 64'd0);
      tick();
      check("wd_at_limit", {62'd0, div_err, busy}, {62'd0, 2'b11});
      for (int i = 0; i < 10; i++) tick();
      check("wd_saturated", {61'd0, div_err, busy, stall_o}, {61'd0, 3'b111});
      tie_low = 1'b0;
      n = 0;
      while (!res_valid && n < 100) begin tick(); n++; end
      check("wd_late_result", {res_hi, res_lo}, {32'd2, 32'd14});
      ex_advance = 1'b1;
      tick();
      ex_advance = 1'b0; req_valid = 1'b0;
      check("wd_sticky", {62'd0, div_err, busy}, {62'd0, 2'b10});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("wd_cleared", 64'(div_err), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
